accumulator_stream_controller: RTL and testbench
================================================

# accumulator_stream_controller

Front-end and result collector for `pipelined_accumulator`. Accepts a valid/ready stream of lane vectors grouped into fixed-length frames and drives the accumulator's `new_sum`/`data_in` inputs, inserting zeros on bubbles. It tracks the accumulator's pipeline latency, captures each completed frame sum from `data_out`, and returns sums through a valid/ready output FIFO with credit-based backpressure. It sits between a lane-vector producer (e.g. a ternary-weight MAC stage) and the downstream consumer of sums.

## Interface
- `IN_BITWIDTH`, 8, signed width of each input lane.
- `OUT_BITWIDTH`, 10, sum width is `OUT_BITWIDTH+1` bits, signed.
- `LOG2_NO_IN`, 1, number of lanes is `NO_IN = 2**LOG2_NO_IN`.
- `SUM_LEN`, 3, accepted beats per frame, ≥1.
- `FIFO_DEPTH`, 2, result FIFO entries, ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  beat is accepted when `in_valid && in_ready`.
- `in_data`  in  `NO_IN*IN_BITWIDTH`  packed signed lanes; lane i is at bits `[i*IN_BITWIDTH +: IN_BITWIDTH]`.
- `acc_new_sum`  out  1  to accumulator `new_sum`; registered.
- `acc_data_in`  out  `NO_IN*IN_BITWIDTH`  to accumulator `data_in`; registered.
- `acc_data_out`  in  `OUT_BITWIDTH+1`  from accumulator `data_out`.
- `out_valid`  out  1  `out_data` holds a completed sum.
- `out_ready`  in  1  consumer accepts on `out_valid && out_ready`.
- `out_data`  out  `OUT_BITWIDTH+1`  signed frame sum.

## Operation
- `beat_cnt` (0..`SUM_LEN-1`) counts accepted beats. It wraps to 0 after the last beat. A beat is first when `beat_cnt==0` and last when `beat_cnt==SUM_LEN-1`. With `SUM_LEN=1`, every beat is both first and last.
- Each cycle the drive register loads as follows:
  - On an accepted beat: `acc_data_in<=in_data` and `acc_new_sum<=first`.
  - Otherwise: `acc_data_in<=0` and `acc_new_sum<=0`. Zeros leave the running sum unchanged, so bubbles mid-frame are transparent.
- Capture pipeline: `last_pipe` is a shift register of depth `LOG2_NO_IN+2`, fed by accepted-last. When its tail is 1, `acc_data_out` is pushed into the FIFO.
- Credits:
  - `inflight` increments on an accepted last beat and decrements on capture; both in one cycle leave it unchanged.
  - `in_ready = (beat_cnt!=SUM_LEN-1) || (inflight + fifo_count < FIFO_DEPTH)`.
  - Non-last beats are never stalled. A capture always finds a free entry, so the FIFO never overflows.
- FIFO is first-word-fall-through. `out_data` is stable while `out_valid && !out_ready`. Push and pop in the same cycle are allowed at any fill level, including full.
- Arithmetic is done by the accumulator (sign extension to `OUT_BITWIDTH+1`). This block passes values through unmodified; overflow wraps two's-complement.

## Timing
- Reset (async assert, sync release) sets these values:
  - `acc_new_sum=0`, `acc_data_in=0`.
  - `beat_cnt=0`, `inflight=0`, `last_pipe=0`, FIFO empty.
  - `out_valid=0`, `out_data=0`.
  - `in_ready=1` after release.
- Latency from the accepted last-beat cycle T:
  - The sum is captured at edge T+`LOG2_NO_IN`+2.
  - `out_valid` rises the cycle after capture: T+`LOG2_NO_IN`+3, i.e. T+4 for `LOG2_NO_IN=1`.
- Frames may be back-to-back; the first beat of frame n+1 may directly follow the last beat of frame n.
- Reset mid-frame discards partial frames, in-flight sums and FIFO contents. The accumulator is unreset, but `last_pipe` is cleared, so no stale capture occurs. The next frame starts with `acc_new_sum=1`.
- `in_ready` is combinational from `beat_cnt`, `inflight` and `fifo_count` only. It does not depend on `in_valid`.

## Test plan
Defaults for all scenarios except 5: `LOG2_NO_IN=1`, `IN_BITWIDTH=8`, `OUT_BITWIDTH=10`, `SUM_LEN=3`, `FIFO_DEPTH=2`, paired with a real `pipelined_accumulator`.

1. Contiguous frame {1,2},{3,4},{5,6}, `out_ready=1` -> `out_valid` for one cycle, 4 cycles after the last beat, `out_data=21`.
2. Bubbles: {-1,-2}, 2 idle cycles, {10,0}, 1 idle cycle, {4,4} -> `out_data=15`; `acc_data_in=0` and `acc_new_sum=0` during the idle cycles.
3. `out_ready=0`, three back-to-back frames summing to 21, 3, -6 -> `in_ready` drops on the third frame's last beat and stays low. Raise `out_ready` -> pops 21 then 3 in order; the last beat is then accepted and -6 follows; no loss or reorder.
4. Extremes: three beats of {-128,-128} -> `out_data=-768`; three beats of {127,127} -> `out_data=762`.
5. `SUM_LEN=1`: beats {1,1},{2,3},{-4,0} back-to-back -> `acc_new_sum` high on every beat; outputs 2, 5, -4 on consecutive cycles.
6. Reset mid-frame: two beats of {50,50}, pulse `rst_n` low for 1 cycle, then frame {1,0},{1,0},{1,0} -> `out_valid=0` throughout reset; the only output after reset is 3.

Source files
------------

// File: rtl/accumulator_stream_controller.sv
// accumulator_stream_controller
//
// Front-end and result collector for pipelined_accumulator. It accepts a
// valid/ready stream of lane vectors grouped into frames of SUM_LEN beats. It
// drives the accumulator's new_sum/data_in inputs and substitutes zeros on
// bubbles. It captures each completed frame sum from acc_data_out once the
// accumulator pipeline has drained. Sums are returned through a
// first-word-fall-through FIFO. Credits are reserved per in-flight frame, so
// the FIFO can never overflow.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_data             NO_IN packed signed lanes, lane i at [i*IN_BITWIDTH +: IN_BITWIDTH]
//   acc_new_sum         registered new_sum to the accumulator
//   acc_data_in         registered data_in to the accumulator
//   acc_data_out        running sum from the accumulator
//   out_valid/out_ready result handshake
//   out_data            signed frame sum (zero while out_valid is low)
module accumulator_stream_controller #(
  parameter int unsigned IN_BITWIDTH  = 8,
  parameter int unsigned OUT_BITWIDTH = 10,
  parameter int unsigned LOG2_NO_IN   = 1,
  parameter int unsigned SUM_LEN      = 3,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [(1 << LOG2_NO_IN)*IN_BITWIDTH-1:0]     in_data,
  output logic                                         acc_new_sum,
  output logic [(1 << LOG2_NO_IN)*IN_BITWIDTH-1:0]     acc_data_in,
  input  logic [OUT_BITWIDTH:0]                        acc_data_out,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [OUT_BITWIDTH:0]                        out_data
);

  localparam int unsigned NoIn  = 1 << LOG2_NO_IN;
  localparam int unsigned DataW = NoIn * IN_BITWIDTH;
  localparam int unsigned SumW  = OUT_BITWIDTH + 1;
  // Adder-tree stages plus the accumulate register plus the drive register.
  localparam int unsigned PipeD = LOG2_NO_IN + 2;
  localparam int unsigned CntW  = (SUM_LEN > 1) ? $clog2(SUM_LEN) : 1;
  localparam int unsigned CredW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CntW-1:0] LastBeat = CntW'(SUM_LEN - 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFO_DEPTH - 1);

  logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CredW-1:0] inflight_q, inflight_d;
  logic [CredW-1:0] fifo_count_q, fifo_count_d;
  logic [PipeD-1:0] last_pipe_q, last_pipe_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic             acc_new_sum_q, acc_new_sum_d;
  logic [DataW-1:0] acc_data_in_q, acc_data_in_d;
  logic [SumW-1:0]  fifo_mem_q [FIFO_DEPTH];

  logic is_first, is_last, credit_ok;
  logic accept, accept_last, capture, push, pop;

  always_comb begin
    is_first    = (beat_cnt_q == '0);
    is_last     = (beat_cnt_q == LastBeat);
    // Reserve a FIFO slot for every frame whose sum is still in the pipeline.
    credit_ok   = (32'(inflight_q) + 32'(fifo_count_q)) < FIFO_DEPTH;
    in_ready    = !is_last || credit_ok;
    accept      = in_valid && in_ready;
    accept_last = accept && is_last;
    capture     = last_pipe_q[PipeD-1];
    push        = capture;
    out_valid   = (fifo_count_q != '0);
    pop         = out_valid && out_ready;
    out_data    = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
    acc_new_sum = acc_new_sum_q;
    acc_data_in = acc_data_in_q;
  end

  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    inflight_d    = inflight_q;
    fifo_count_d  = fifo_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    last_pipe_d   = {last_pipe_q[PipeD-2:0], accept_last};
    // Zeros on bubbles keep the running sum unchanged.
    acc_new_sum_d = accept && is_first;
    acc_data_in_d = accept ? in_data : '0;

    if (accept) begin
      beat_cnt_d = is_last ? '0 : beat_cnt_q + CntW'(1);
    end

    unique case ({accept_last, capture})
      2'b10:   inflight_d = inflight_q + CredW'(1);
      2'b01:   inflight_d = inflight_q - CredW'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CredW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CredW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q    <= '0;
      inflight_q    <= '0;
      fifo_count_q  <= '0;
      last_pipe_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      acc_new_sum_q <= 1'b0;
      acc_data_in_q <= '0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      inflight_q    <= inflight_d;
      fifo_count_q  <= fifo_count_d;
      last_pipe_q   <= last_pipe_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      acc_new_sum_q <= acc_new_sum_d;
      acc_data_in_q <= acc_data_in_d;
    end
  end

  // Storage needs no reset; out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= acc_data_out;
    end
  end

endmodule

// File: tb/tb_accumulator_stream_controller.sv
module tb_accumulator_stream_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT 1: default parameters.
  logic               in_valid1, in_ready1, acc_new_sum1, out_valid1, out_ready1;
  logic [15:0]        in_data1, acc_data_in1;
  logic [10:0]        acc_data_out1, out_data1;
  // DUT 2: SUM_LEN=1, deeper FIFO so single-beat frames stream back-to-back.
  logic               in_valid2, in_ready2, acc_new_sum2, out_valid2, out_ready2;
  logic [15:0]        in_data2, acc_data_in2;
  logic [10:0]        acc_data_out2, out_data2;

  accumulator_stream_controller dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid1),
    .in_ready     (in_ready1),
    .in_data      (in_data1),
    .acc_new_sum  (acc_new_sum1),
    .acc_data_in  (acc_data_in1),
    .acc_data_out (acc_data_out1),
    .out_valid    (out_valid1),
    .out_ready    (out_ready1),
    .out_data     (out_data1)
  );

  accumulator_stream_controller #(
    .SUM_LEN    (1),
    .FIFO_DEPTH (4)
  ) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid2),
    .in_ready     (in_ready2),
    .in_data      (in_data2),
    .acc_new_sum  (acc_new_sum2),
    .acc_data_in  (acc_data_in2),
    .acc_data_out (acc_data_out2),
    .out_valid    (out_valid2),
    .out_ready    (out_ready2),
    .out_data     (out_data2)
  );

  // Accumulator models (LOG2_NO_IN=1): one adder-tree stage, then the
  // accumulate register. Not reset, like the real accumulator.
  logic signed [10:0] l10, l11, l20, l21, tree1_q, tree2_q, acc1_q, acc2_q;
  logic               ns1_q, ns2_q;
  assign l10 = $signed(acc_data_in1[7:0]);
  assign l11 = $signed(acc_data_in1[15:8]);
  assign l20 = $signed(acc_data_in2[7:0]);
  assign l21 = $signed(acc_data_in2[15:8]);
  always @(posedge clk) begin
    tree1_q <= l10 + l11;
    ns1_q   <= acc_new_sum1;
    acc1_q  <= ns1_q ? tree1_q : acc1_q + tree1_q;
    tree2_q <= l20 + l21;
    ns2_q   <= acc_new_sum2;
    acc2_q  <= ns2_q ? tree2_q : acc2_q + tree2_q;
  end
  assign acc_data_out1 = acc1_q;
  assign acc_data_out2 = acc2_q;

  // Output monitors: record each popped sum with the edge index of the pop.
  int                 cyc = 0;
  logic signed [10:0] q1[$], q2[$];
  int                 t1[$], t2[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && out_valid1 && out_ready1) begin
      q1.push_back(out_data1);
      t1.push_back(cyc);
    end
    if (rst_n && out_valid2 && out_ready2) begin
      q2.push_back(out_data2);
      t2.push_back(cyc);
    end
  end

  int passes = 0;
  int total  = 0;
  int last_cyc;
  int s5_cyc;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present one beat on DUT 1 at a negedge and hold it until accepted.
  task automatic send(input int a, input int b);
    bit acc;
    acc = 1'b0;
    in_valid1 = 1'b1;
    in_data1  = {8'(b), 8'(a)};
    for (int i = 0; i < 40 && !acc; i++) begin
      acc      = in_ready1;
      last_cyc = cyc;
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    in_data1  = '0;
    check("accept", 32'(acc), 1);
  endtask

  task automatic clear1();
    q1.delete();
    t1.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_new_sum", 32'(acc_new_sum1), 0);
    check("rst_data_in", 32'(acc_data_in1), 0);
    check("rst_out_valid", 32'(out_valid1), 0);
    check("rst_out_data", 32'(out_data1), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready1), 1);

    // 1: contiguous frame -> 21, four cycles after the last beat
    send(1, 2);
    check("s1_first_new_sum", 32'(acc_new_sum1), 1);
    send(3, 4);
    check("s1_mid_new_sum", 32'(acc_new_sum1), 0);
    send(5, 6);
    repeat (8) @(negedge clk);
    check("s1_count", q1.size(), 1);
    check("s1_sum", q1[0], 21);
    check("s1_latency", t1[0], last_cyc + 4);
    check("s1_valid_drops", 32'(out_valid1), 0);
    clear1();

    // 2: bubbles are transparent -> 15
    send(-1, -2);
    check("s2_din_beat", 32'(acc_data_in1), 32'h0000FEFF);
    check("s2_ns_beat", 32'(acc_new_sum1), 1);
    repeat (2) begin
      @(negedge clk);
      check("s2_din_idle", 32'(acc_data_in1), 0);
      check("s2_ns_idle", 32'(acc_new_sum1), 0);
    end
    send(10, 0);
    @(negedge clk);
    check("s2_din_idle2", 32'(acc_data_in1), 0);
    send(4, 4);
    repeat (8) @(negedge clk);
    check("s2_count", q1.size(), 1);
    check("s2_sum", q1[0], 15);
    clear1();

    // 3: backpressure with credits -> 21, 3, -6 in order
    out_ready1 = 1'b0;
    send(1, 2); send(3, 4); send(5, 6);
    send(1, 0); send(1, 0); send(1, 0);
    send(-1, -1); send(-1, -1);
    in_valid1 = 1'b1;
    in_data1  = {8'hFF, 8'hFF};
    check("s3_stall", 32'(in_ready1), 0);
    repeat (3) begin
      @(negedge clk);
      check("s3_stall_hold", 32'(in_ready1), 0);
    end
    check("s3_out_valid_held", 32'(out_valid1), 1);
    check("s3_head_stable", out_data1, 21);
    out_ready1 = 1'b1;
    send(-1, -1);
    repeat (10) @(negedge clk);
    check("s3_count", q1.size(), 3);
    check("s3_sum0", q1[0], 21);
    check("s3_sum1", q1[1], 3);
    check("s3_sum2", q1[2], -6);
    clear1();

    // 4: extremes
    repeat (3) send(-128, -128);
    repeat (8) @(negedge clk);
    check("s4_min_count", q1.size(), 1);
    check("s4_min", q1[0], -768);
    clear1();
    repeat (3) send(127, 127);
    repeat (8) @(negedge clk);
    check("s4_max_count", q1.size(), 1);
    check("s4_max", q1[0], 762);
    clear1();

    // 5: SUM_LEN=1, every beat is a whole frame
    s5_cyc = cyc;
    in_valid2 = 1'b1;
    in_data2 = {8'd1, 8'd1};
    check("s5_ready0", 32'(in_ready2), 1);
    @(negedge clk);
    check("s5_ns0", 32'(acc_new_sum2), 1);
    in_data2 = {8'd3, 8'd2};
    check("s5_ready1", 32'(in_ready2), 1);
    @(negedge clk);
    check("s5_ns1", 32'(acc_new_sum2), 1);
    in_data2 = {8'd0, 8'hFC};
    check("s5_ready2", 32'(in_ready2), 1);
    @(negedge clk);
    check("s5_ns2", 32'(acc_new_sum2), 1);
    in_valid2 = 1'b0;
    in_data2  = '0;
    repeat (8) @(negedge clk);
    check("s5_count", q2.size(), 3);
    check("s5_sum0", q2[0], 2);
    check("s5_sum1", q2[1], 5);
    check("s5_sum2", q2[2], -4);
    check("s5_t0", t2[0], s5_cyc + 4);
    check("s5_t1", t2[1], s5_cyc + 5);
    check("s5_t2", t2[2], s5_cyc + 6);

    // 6: reset mid-frame discards the partial frame
    send(50, 50); send(50, 50);
    rst_n = 1'b0;
    @(negedge clk);
    check("s6_rst_valid", 32'(out_valid1), 0);
    check("s6_rst_ns", 32'(acc_new_sum1), 0);
    check("s6_rst_din", 32'(acc_data_in1), 0);
    rst_n = 1'b1;
    send(1, 0);
    check("s6_first_ns", 32'(acc_new_sum1), 1);
    send(1, 0); send(1, 0);
    repeat (8) @(negedge clk);
    check("s6_count", q1.size(), 1);
    check("s6_sum", q1[0], 3);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
